regfile_wr_arbiter: RTL



---
 rtl/regfile_wr_arbiter_if.sv | 27 ++
 rtl/regfile_wr_arbiter.sv | 81 ++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus between the two requesters and the regfile write port.
interface regfile_wr_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
);
  logic               req0_valid;
  logic [REGBITS-1:0] req0_addr;
  logic [WIDTH-1:0]   req0_data;
  logic               req0_ready;
  logic               req1_valid;
  logic [REGBITS-1:0] req1_addr;
  logic [WIDTH-1:0]   req1_data;
  logic               req1_ready;
  logic               regwrite;
  logic [REGBITS-1:0] wa;
  logic [WIDTH-1:0]   wd;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, regwrite, wa, wd
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, regwrite, wa, wd
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Clears the register file after reset, then round-robin arbitrates two
// writeback requesters onto the single registered regfile write port.
module regfile_wr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wr_arbiter_if.slave  bus,
  output logic                 init_done,
  output logic [7:0]           conflict_cnt
);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  logic [REGBITS-1:0] clr_ptr;
  logic               last;
  logic               grant0;
  logic               grant1;
  logic               both_valid;

  // Both valid: the requester that did not win the last handshake goes first.
  always_comb begin
    both_valid = bus.req0_valid && bus.req1_valid;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (state == RUN) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || last);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last);
    end
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      clr_ptr      <= {{(REGBITS-1){1'b0}}, 1'b1};
      last         <= 1'b1;
      bus.regwrite <= 1'b0;
      bus.wa       <= '0;
      bus.wd       <= '0;
      init_done    <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          bus.regwrite <= 1'b1;
          bus.wa       <= clr_ptr;
          bus.wd       <= '0;
          clr_ptr      <= clr_ptr + 1'b1;
          if (clr_ptr == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          // Writes to $zero are acknowledged but never reach the regfile.
          if (grant0) begin
            bus.wa       <= bus.req0_addr;
            bus.wd       <= bus.req0_data;
            bus.regwrite <= (bus.req0_addr != '0);
            last         <= 1'b0;
          end else if (grant1) begin
            bus.wa       <= bus.req1_addr;
            bus.wd       <= bus.req1_data;
            bus.regwrite <= (bus.req1_addr != '0);
            last         <= 1'b1;
          end else begin
            bus.regwrite <= 1'b0;
          end
          if (both_valid && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + 8'd1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
